// File: rtl/prio_arbiter_n_if.sv
// Request/grant bundle between N requesters and the arbiter owning a shared resource.
// Requester side drives req/ack; arbiter side drives the registered grant and req_pending.
interface prio_arbiter_n_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    // Handshake: a requester holds req[i] until served. Once gnt_valid=1 the grant is
    // frozen until the owner pulses ack for one cycle; ack has no effect while gnt_valid=0.
    logic [N-1:0]     req;
    logic             ack;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     gnt_onehot;
    logic             req_pending;

    modport master (
        output req, ack,
        input  gnt_valid, gnt_idx, gnt_onehot, req_pending
    );

    modport slave (
        input  req, ack,
        output gnt_valid, gnt_idx, gnt_onehot, req_pending
    );
endinterface

// File: rtl/prio_arbiter_n.sv
// Registered N-input arbiter: grant held until ack, back-to-back re-arbitration on ack.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed (highest index wins).
module prio_arbiter_n #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    prio_arbiter_n_if.slave  bus,
    output logic             state_dbg,
    output logic [IDX_W-1:0] last_idx_dbg
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] gnt_idx, idx_nxt;
    logic [N-1:0]     gnt_onehot, oh_nxt;
    logic [IDX_W-1:0] last_idx, last_nxt;
    logic [N-1:0]     arb_in;
    logic [IDX_W-1:0] winner;
    logic             load;

    function automatic logic [IDX_W-1:0] highest_set(input logic [N-1:0] v);
        logic [IDX_W-1:0] h;
        h = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) h = IDX_W'(i);
        end
        return h;
    endfunction

    // In IDLE the whole request vector competes; on ack the current owner is masked out.
    assign arb_in = (state == IDLE) ? bus.req : (bus.req & ~gnt_onehot);

`ifdef ROUND_ROBIN_EN
    // Rotate so bit m holds requester (last_idx+m) mod N; the highest m is then the
    // first hit of the search last_idx-1, last_idx-2, ... wrapping down to last_idx.
    logic [2*N-1:0]   dbl_shift;
    logic [IDX_W-1:0] rot_pos;
    logic [IDX_W:0]   rot_sum;

    always_comb begin
        dbl_shift = {arb_in, arb_in} >> last_idx;
        rot_pos   = highest_set(dbl_shift[N-1:0]);
        rot_sum   = {1'b0, last_idx} + {1'b0, rot_pos};
        if (rot_sum >= (IDX_W+1)'(N)) rot_sum = rot_sum - (IDX_W+1)'(N);
        winner    = rot_sum[IDX_W-1:0];
    end
`else
    assign winner = highest_set(arb_in);
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = gnt_idx;
        oh_nxt    = gnt_onehot;
        last_nxt  = last_idx;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    load      = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    if (|arb_in) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        oh_nxt    = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            idx_nxt         = winner;
            oh_nxt          = '0;
            oh_nxt[winner]  = 1'b1;
            last_nxt        = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            last_idx   <= '0;
        end else begin
            state      <= state_nxt;
            gnt_idx    <= idx_nxt;
            gnt_onehot <= oh_nxt;
            last_idx   <= last_nxt;
        end
    end

    assign bus.gnt_valid   = (state == GRANT);
    assign bus.gnt_idx     = gnt_idx;
    assign bus.gnt_onehot  = gnt_onehot;
    assign bus.req_pending = |bus.req;
    assign state_dbg       = (state == GRANT);
    assign last_idx_dbg    = last_idx;
endmodule
